// File: rtl/setpoint_entry.sv
// Front-panel setpoint editor: stages up/down edits in a shadow register with
// auto-repeat and clamping, then commits on SET or discards on inactivity.
module setpoint_entry #(
  parameter int unsigned T_MIN        = 50,
  parameter int unsigned T_MAX        = 90,
  parameter int unsigned T_DEFAULT    = 70,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter int unsigned TIMEOUT      = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_set,
  output logic [7:0] desired_temp,
  output logic       temp_set,
  output logic [7:0] edit_temp,
  output logic       editing
);

  localparam logic [7:0]  TMin      = 8'(T_MIN);
  localparam logic [7:0]  TMax      = 8'(T_MAX);
  localparam logic [7:0]  TDefault  = 8'(T_DEFAULT);
  localparam logic [31:0] DelayLast = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RateLast  = 32'(REPEAT_RATE - 1);
  localparam logic [31:0] TmoLast   = 32'(TIMEOUT - 1);

  typedef enum logic {StIdle, StEdit} state_e;

  state_e      state_q, state_d;
  logic        up_q, down_q, set_q;
  logic        armed_q;
  logic [31:0] rpt_q, rpt_d;
  logic        rpt_phase_q, rpt_phase_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  desired_q, desired_d;
  logic [7:0]  edit_q, edit_d;
  logic        temp_set_q, temp_set_d;

  // Rises are masked for one cycle after reset so a button held through
  // reset release is not mistaken for a fresh press.
  logic up_rise, down_rise, set_rise;
  logic lone_up, lone_down, lone_any, any_btn;
  logic step_rise, rpt_hit, step_req, tmo_hit, commit;
  logic [7:0] step_val;

  assign up_rise   = armed_q & btn_up & ~up_q;
  assign down_rise = armed_q & btn_down & ~down_q;
  assign set_rise  = armed_q & btn_set & ~set_q;
  assign lone_up   = btn_up & ~btn_down;
  assign lone_down = btn_down & ~btn_up;
  assign lone_any  = lone_up | lone_down;
  assign any_btn   = btn_up | btn_down | btn_set;
  assign step_rise = (lone_up & up_rise) | (lone_down & down_rise);
  assign rpt_hit   = lone_any & ~step_rise & (state_q == StEdit) &
                     (rpt_phase_q ? (rpt_q == RateLast) : (rpt_q == DelayLast));
  assign step_req  = step_rise | rpt_hit;
  assign tmo_hit   = (state_q == StEdit) & ~any_btn & (tmo_q == TmoLast);
  assign commit    = (state_q == StEdit) & set_rise;
  assign step_val  = lone_up ? ((edit_q >= TMax) ? TMax : edit_q + 8'd1)
                             : ((edit_q <= TMin) ? TMin : edit_q - 8'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic: SET beats timeout beats stepping.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (step_rise) state_d = StEdit;
      StEdit: if (commit || tmo_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: staged/committed words, strobe and counters.
  always_comb begin
    desired_d   = desired_q;
    edit_d      = edit_q;
    temp_set_d  = 1'b0;
    rpt_d       = rpt_q + 32'd1;
    rpt_phase_d = rpt_phase_q;
    tmo_d       = tmo_q + 32'd1;

    // Repeat sequence restarts on release, on both-held, or on a new press.
    if (!lone_any || step_rise || state_q == StIdle) begin
      rpt_d       = '0;
      rpt_phase_d = 1'b0;
    end else if (rpt_hit) begin
      rpt_d       = '0;
      rpt_phase_d = 1'b1;
    end

    if (state_q == StIdle || any_btn || tmo_hit) tmo_d = '0;

    unique case (state_q)
      StIdle: edit_d = step_rise ? step_val : desired_q;
      StEdit: begin
        if (commit) begin
          desired_d  = edit_q;
          temp_set_d = 1'b1;
        end else if (tmo_hit) begin
          edit_d = desired_q;
        end else if (step_req) begin
          edit_d = step_val;
        end
      end
      default: edit_d = desired_q;
    endcase
  end

  // Datapath and edge-detect registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      set_q       <= 1'b0;
      armed_q     <= 1'b0;
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
      tmo_q       <= '0;
      desired_q   <= TDefault;
      edit_q      <= TDefault;
      temp_set_q  <= 1'b0;
    end else begin
      up_q        <= btn_up;
      down_q      <= btn_down;
      set_q       <= btn_set;
      armed_q     <= 1'b1;
      rpt_q       <= rpt_d;
      rpt_phase_q <= rpt_phase_d;
      tmo_q       <= tmo_d;
      desired_q   <= desired_d;
      edit_q      <= edit_d;
      temp_set_q  <= temp_set_d;
    end
  end

  assign desired_temp = desired_q;
  assign edit_temp    = edit_q;
  assign temp_set     = temp_set_q;
  assign editing      = (state_q == StEdit);

endmodule

// File: tb/tb_setpoint_entry.sv
// Directed bench for setpoint_entry with small repeat/timeout constants.
module tb_setpoint_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_set = 1'b0;
  logic [7:0] desired_temp;
  logic       temp_set;
  logic [7:0] edit_temp;
  logic       editing;

  int n_cmp = 0;
  int n_err = 0;
  int bad;
  logic seen;

  setpoint_entry #(
    .T_MIN(50), .T_MAX(90), .T_DEFAULT(70),
    .REPEAT_DELAY(8), .REPEAT_RATE(4), .TIMEOUT(32)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_set(btn_set),
    .desired_temp(desired_temp), .temp_set(temp_set), .edit_temp(edit_temp),
    .editing(editing)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic tap_up();
    btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
  endtask

  task automatic tap_down();
    btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
  endtask

  task automatic commit_check(input string tag, input logic [7:0] exp);
    btn_set = 1'b1;
    tick();
    check_eq({tag, "_strobe"}, temp_set, 1);
    check_eq({tag, "_desired"}, desired_temp, exp);
    check_eq({tag, "_editing"}, editing, 0);
    btn_set = 1'b0;
    tick();
    check_eq({tag, "_strobe_low"}, temp_set, 0);
  endtask

  initial begin
    // 1: reset and taps
    reset = 1'b1;
    tick();
    check_eq("rst_desired", desired_temp, 70);
    check_eq("rst_edit", edit_temp, 70);
    check_eq("rst_temp_set", temp_set, 0);
    check_eq("rst_editing", editing, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      btn_up = 1'b1;
      tick();
      check_eq("tap_up_edit", edit_temp, 71 + i);
      check_eq("tap_up_editing", editing, 1);
      btn_up = 1'b0;
      tick();
    end
    check_eq("tap_desired_unchanged", desired_temp, 70);
    commit_check("commit73", 73);

    // 2: auto-repeat down
    do_reset();
    btn_down = 1'b1;
    tick();
    check_eq("rpt_first", edit_temp, 69);
    repeat (7) tick();
    check_eq("rpt_before_delay", edit_temp, 69);
    tick();
    check_eq("rpt_delay", edit_temp, 68);
    repeat (4) tick();
    check_eq("rpt_rate1", edit_temp, 67);
    repeat (8) tick();
    check_eq("rpt_final", edit_temp, 65);
    btn_down = 1'b0;
    tick();
    check_eq("rpt_release", edit_temp, 65);
    commit_check("commit65", 65);

    // 3: clamping both ways
    do_reset();
    repeat (18) tap_up();
    check_eq("clamp_start88", edit_temp, 88);
    btn_up = 1'b1;
    bad = 0;
    repeat (40) begin
      tick();
      if (edit_temp > 8'd90 || edit_temp == 8'd0) bad++;
    end
    check_eq("clamp_hi_bound", bad, 0);
    check_eq("clamp_hi_final", edit_temp, 90);
    btn_up = 1'b0;
    tick();
    repeat (39) tap_down();
    check_eq("clamp_start51", edit_temp, 51);
    btn_down = 1'b1;
    bad = 0;
    repeat (40) begin
      tick();
      if (edit_temp < 8'd50) bad++;
    end
    check_eq("clamp_lo_bound", bad, 0);
    check_eq("clamp_lo_final", edit_temp, 50);
    btn_down = 1'b0;
    tick();
    commit_check("commit50", 50);

    // 4: simultaneous buttons
    do_reset();
    tap_up();
    tap_up();
    btn_up = 1'b1;
    btn_down = 1'b1;
    repeat (20) tick();
    check_eq("both_held_edit", edit_temp, 72);
    check_eq("both_held_editing", editing, 1);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick();
    btn_set = 1'b1;
    btn_up = 1'b1;
    tick();
    check_eq("set_up_strobe", temp_set, 1);
    check_eq("set_up_desired", desired_temp, 72);
    check_eq("set_up_edit", edit_temp, 72);
    btn_set = 1'b0;
    btn_up = 1'b0;
    tick();
    check_eq("set_up_after_edit", edit_temp, 72);
    check_eq("set_up_after_strobe", temp_set, 0);
    check_eq("set_up_after_editing", editing, 0);

    // 5: timeout discards the edit
    do_reset();
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    check_eq("tmo_staged", edit_temp, 71);
    seen = 1'b0;
    repeat (15) begin
      tick();
      seen |= temp_set;
    end
    check_eq("tmo_still_editing", editing, 1);
    check_eq("tmo_still_staged", edit_temp, 71);
    repeat (25) begin
      tick();
      seen |= temp_set;
    end
    check_eq("tmo_edit_restored", edit_temp, 70);
    check_eq("tmo_editing", editing, 0);
    check_eq("tmo_no_strobe", seen, 0);
    check_eq("tmo_desired", desired_temp, 70);

    // 6: reset mid-edit with up held
    do_reset();
    repeat (5) tap_up();
    check_eq("mid_staged75", edit_temp, 75);
    btn_up = 1'b1;
    reset = 1'b1;
    tick();
    check_eq("mid_rst_desired", desired_temp, 70);
    check_eq("mid_rst_edit", edit_temp, 70);
    check_eq("mid_rst_temp_set", temp_set, 0);
    check_eq("mid_rst_editing", editing, 0);
    reset = 1'b0;
    repeat (12) tick();
    check_eq("held_thru_rst_edit", edit_temp, 70);
    check_eq("held_thru_rst_editing", editing, 0);
    btn_up = 1'b0;
    tick();
    btn_up = 1'b1;
    tick();
    check_eq("repress_edit", edit_temp, 71);
    check_eq("repress_editing", editing, 1);
    btn_up = 1'b0;
    tick();
    do_reset();
    btn_set = 1'b1;
    tick();
    check_eq("idle_set_strobe", temp_set, 0);
    check_eq("idle_set_editing", editing, 0);
    check_eq("idle_set_desired", desired_temp, 70);
    btn_set = 1'b0;
    tick();
    check_eq("idle_set_strobe_after", temp_set, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
